// File: rtl/alu_iter_pkg.sv
// rtl/alu_iter_pkg.sv - shared types and single-cycle calculator for alu_iter
package lib_alu_iter;

    // Widest datapath the shared calculator handles; callers zero-extend into it.
    localparam int CALC_W = 64;
    localparam int SH_W   = 6;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_SLL   = 4'h2,
        OP_SRL   = 4'h3,
        OP_SRA   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_MUL   = 4'h8,
        OP_MULHU = 4'h9,
        OP_DIVU  = 4'hA,
        OP_REMU  = 4'hB
    } ALU_OP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ALU_STATE;

    // Single-cycle result computed at width w; bits above w are forced to zero.
    function automatic logic [CALC_W-1:0] fn_calc_w(
        input logic [3:0]        op,
        input logic [CALC_W-1:0] a,
        input logic [CALC_W-1:0] b,
        input logic [SH_W-1:0]   sh,
        input int                w
    );
        logic [CALC_W-1:0] mask;
        logic [CALC_W-1:0] a_m;
        logic [CALC_W-1:0] a_se;
        logic [CALC_W-1:0] res;
        logic [SH_W-1:0]   msb;
        mask = (CALC_W'(1) << w) - CALC_W'(1);
        msb  = SH_W'(w - 1);
        a_m  = a & mask;
        a_se = a[msb] ? (a_m | ~mask) : a_m;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_SLL:  res = a_m << sh;
            OP_SRL:  res = a_m >> sh;
            OP_SRA:  res = $unsigned($signed(a_se) >>> sh);
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            default: res = '0;
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv_iter.sv
// rtl/alu_iter_muldiv_iter.sv - one-bit-per-cycle unsigned multiply / restoring divide
module muldiv_iter
    import lib_alu_iter::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  ALU_OP           op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              hi_q, hi_d;

    logic [XLEN:0]     rem_try;
    logic [XLEN:0]     diff;
    logic              qbit;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;

    // a_q is shifted out MSB first in both modes: multiplier bits or dividend bits.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        rem_try  = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
        diff     = rem_try - {1'b0, b_q};
        qbit     = ~diff[XLEN];
        mul_next = {acc_q[2*XLEN-2:0], 1'b0} + (a_q[XLEN-1] ? {{XLEN{1'b0}}, b_q} : '0);
        div_next = {(qbit ? diff[XLEN-1:0] : rem_try[XLEN-1:0]), acc_q[XLEN-2:0], qbit};
        if (start) begin
            a_d      = a;
            b_d      = b;
            acc_d    = '0;
            cnt_d    = CW'(XLEN - 1);
            is_div_d = (op == OP_DIVU) || (op == OP_REMU);
            hi_d     = (op == OP_MULHU) || (op == OP_REMU);
        end else if (step) begin
            acc_d = is_div_q ? div_next : mul_next;
            a_d   = a_q << 1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign done   = step && !start && (cnt_q == '0);
    assign result = hi_q ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];

    // Operand, accumulator and step-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            hi_q     <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - handshaked execute unit with iterative mul/div
module alu_iter
    import lib_alu_iter::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);

    ALU_STATE        state_q, state_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;

    logic [CALC_W-1:0] calc_full;
    logic [XLEN-1:0]   calc_res;
    logic              accept;
    logic              is_iter;
    logic              md_start;
    logic              md_step;
    logic              md_done;
    logic [XLEN-1:0]   md_result;

    assign calc_full = fn_calc_w(in_op, CALC_W'(in_a), CALC_W'(in_b), SH_W'(in_b[SHW-1:0]), XLEN);
    assign calc_res  = calc_full[XLEN-1:0];

    generate
        if (XLEN < CALC_W) begin : g_calc_hi
            logic unused_calc_hi;
            assign unused_calc_hi = |calc_full[CALC_W-1:XLEN];
        end
    endgenerate

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign accept    = in_valid && in_ready;
    assign is_iter   = in_op[3] && !in_op[2];
    assign md_start  = accept && is_iter;
    assign md_step   = (state_q == BUSY);

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .step   (md_step),
        .op     (ALU_OP'(in_op)),
        .a      (in_a),
        .b      (in_b),
        .done   (md_done),
        .result (md_result)
    );

    // Next state and result capture; flush overrides every transition.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        out_tag_d = in_tag;
                        if (is_iter) begin
                            state_d = BUSY;
                        end else begin
                            out_data_d = calc_res;
                            state_d    = DONE;
                        end
                    end
                end
                BUSY: begin
                    if (md_done) begin
                        out_data_d = md_result;
                        state_d    = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - scoreboard bench for alu_iter at XLEN 32 and 16
module tb_alu_iter;

    localparam int TAGW = 5;

    typedef struct {
        logic [31:0]     data;
        logic [TAGW-1:0] tag;
        int              lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q32[$];
    exp_t q16[$];
    bit   done16 = 1'b0;

    logic            rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]      in_op;
    logic [31:0]     in_a, in_b, out_data;
    logic [TAGW-1:0] in_tag, out_tag;

    logic            rst_h, flush_h, in_valid_h, in_ready_h, out_valid_h, out_ready_h, busy_h;
    logic [3:0]      in_op_h;
    logic [15:0]     in_a_h, in_b_h, out_data_h;
    logic [TAGW-1:0] in_tag_h, out_tag_h;

    alu_iter #(.XLEN(32), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy)
    );

    alu_iter #(.XLEN(16), .TAGW(TAGW)) dut16 (
        .clk(clk), .rst(rst_h), .flush(flush_h), .in_valid(in_valid_h), .in_ready(in_ready_h),
        .in_op(in_op_h), .in_a(in_a_h), .in_b(in_b_h), .in_tag(in_tag_h),
        .out_valid(out_valid_h), .out_ready(out_ready_h), .out_data(out_data_h),
        .out_tag(out_tag_h), .busy(busy_h)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor for the 32-bit unit: latency is measured from the accept cycle.
    int acc32 = 0, rise32 = 0;
    logic prev32 = 1'b0;
    always @(negedge clk) begin : mon32
        exp_t e;
        if (rst) begin
            prev32 = 1'b0;
        end else begin
            if (in_valid && in_ready) acc32 = cyc;
            if (out_valid && !prev32) rise32 = cyc;
            prev32 = out_valid;
            if (out_valid && out_ready) begin
                if (q32.size() == 0) begin
                    n_total++;
                    $display("FAIL spurious_out32: got data %0h tag %0h, expected no output", out_data, out_tag);
                end else begin
                    e = q32.pop_front();
                    chk("data32", out_data, e.data);
                    chk("tag32", out_tag, e.tag);
                    chk("lat32", rise32 - acc32, e.lat);
                end
            end
        end
    end

    int acc16 = 0, rise16 = 0;
    logic prev16 = 1'b0;
    always @(negedge clk) begin : mon16
        exp_t e;
        if (rst_h) begin
            prev16 = 1'b0;
        end else begin
            if (in_valid_h && in_ready_h) acc16 = cyc;
            if (out_valid_h && !prev16) rise16 = cyc;
            prev16 = out_valid_h;
            if (out_valid_h && out_ready_h) begin
                if (q16.size() == 0) begin
                    n_total++;
                    $display("FAIL spurious_out16: got data %0h tag %0h, expected no output", out_data_h, out_tag_h);
                end else begin
                    e = q16.pop_front();
                    chk("data16", {16'h0, out_data_h}, e.data);
                    chk("tag16", out_tag_h, e.tag);
                    chk("lat16", rise16 - acc16, e.lat);
                end
            end
        end
    end

    task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAGW-1:0] tag, input logic [31:0] exp, input int lat, input bit push);
        int w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        if (w >= 100) timeout_fail("issue32_ready");
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        if (push) q32.push_back('{exp, tag, lat});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain32();
        int w = 0;
        while ((q32.size() != 0 || busy) && w < 200) begin @(posedge clk); #1; w++; end
        if (w >= 200) timeout_fail("drain32");
    endtask

    task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [TAGW-1:0] tag, input logic [15:0] exp, input int lat);
        int w = 0;
        while (!in_ready_h && w < 100) begin @(posedge clk); #1; w++; end
        if (w >= 100) timeout_fail("issue16_ready");
        in_valid_h = 1'b1; in_op_h = op; in_a_h = a; in_b_h = b; in_tag_h = tag;
        q16.push_back('{{16'h0, exp}, tag, lat});
        @(posedge clk); #1;
        in_valid_h = 1'b0;
    endtask

    initial begin : drive32
        int viol;
        int w;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1);

        issue32(4'h0, 32'd5, 32'hFFFF_FFFD, 5'd7, 32'd2, 1, 1);
        drain32();
        chk("add_back_idle", {busy, in_ready}, 2'b01);

        issue32(4'h4, 32'h8000_0000, 32'h24, 5'd1, 32'hF800_0000, 1, 1);
        issue32(4'h3, 32'h8000_0000, 32'h24, 5'd2, 32'h0800_0000, 1, 1);
        issue32(4'h1, 32'd3, 32'd5, 5'd3, 32'hFFFF_FFFE, 1, 1);
        issue32(4'h2, 32'd1, 32'h3F, 5'd4, 32'h8000_0000, 1, 1);
        issue32(4'h5, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5, 32'hF000_F000, 1, 1);
        issue32(4'h6, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6, 32'hFFF0_FFF0, 1, 1);
        issue32(4'h7, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8, 32'h0FF0_0FF0, 1, 1);
        issue32(4'hC, 32'h1234, 32'h5678, 5'd9, 32'h0, 1, 1);
        drain32();

        issue32(4'h8, 32'h0001_0000, 32'h0001_0000, 5'd10, 32'h0, 33, 1);
        viol = 0;
        for (int i = 0; i < 32; i++) begin
            if (in_ready || !busy) viol++;
            @(posedge clk); #1;
        end
        chk("busy_in_ready_low", viol, 0);
        drain32();
        issue32(4'h9, 32'h0001_0000, 32'h0001_0000, 5'd11, 32'h1, 33, 1);
        issue32(4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, 33, 1);
        issue32(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h1, 33, 1);

        issue32(4'hA, 32'd100, 32'd7, 5'd14, 32'd14, 33, 1);
        issue32(4'hB, 32'd100, 32'd7, 5'd15, 32'd2, 33, 1);
        issue32(4'hA, 32'h1234, 32'd0, 5'd16, 32'hFFFF_FFFF, 33, 1);
        issue32(4'hB, 32'h1234, 32'd0, 5'd17, 32'h1234, 33, 1);
        issue32(4'hA, 32'hFFFF_FFFF, 32'h10, 5'd18, 32'h0FFF_FFFF, 33, 1);
        issue32(4'hB, 32'hFFFF_FFFF, 32'h10, 5'd19, 32'hF, 33, 1);
        drain32();

        out_ready = 1'b0;
        issue32(4'h7, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5'd9, 32'hAAAA_AAAA, 1, 1);
        w = 0;
        while (!out_valid && w < 10) begin @(posedge clk); #1; w++; end
        if (w >= 10) timeout_fail("bp_out_valid");
        in_valid = 1'b1; in_op = 4'h0; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd20;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_data !== 32'hAAAA_AAAA || out_tag !== 5'd9 || in_ready || !out_valid) viol++;
        end
        chk("backpressure_hold", viol, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain32();
        chk("bp_back_idle", {busy, in_ready}, 2'b01);

        issue32(4'hA, 32'd1000, 32'd3, 5'd21, 32'd0, 33, 0);
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_to_idle", {busy, out_valid}, 2'b00);
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) viol++;
            @(posedge clk); #1;
        end
        chk("flush_no_result", viol, 0);
        issue32(4'h0, 32'd10, 32'd20, 5'd22, 32'd30, 1, 1);
        drain32();

        flush = 1'b1;
        in_valid = 1'b1; in_op = 4'h0; in_a = 32'd1; in_b = 32'd2; in_tag = 5'd23;
        #1 chk("flush_blocks_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_no_accept", busy, 0);

        issue32(4'h0, 32'd1, 32'd1, 5'd24, 32'd2, 1, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_on_xfer_idle", busy, 0);

        issue32(4'h8, 32'd3, 32'd5, 5'd25, 32'd15, 33, 0);
        repeat (6) begin @(posedge clk); #1; end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_state", {busy, out_valid}, 2'b00);
        chk("midrst_data", out_data, 0);
        chk("midrst_tag", out_tag, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue32(4'h1, 32'd7, 32'd9, 5'd26, 32'hFFFF_FFFE, 1, 1);
        drain32();
        repeat (40) begin @(posedge clk); #1; end

        w = 0;
        while (!done16 && w < 2000) begin @(posedge clk); w++; end
        if (w >= 2000) timeout_fail("done16");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : drive16
        int w;
        rst_h = 1'b1; flush_h = 1'b0; in_valid_h = 1'b0; in_op_h = '0; in_a_h = '0;
        in_b_h = '0; in_tag_h = '0; out_ready_h = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_h = 1'b0;
        issue16(4'h9, 16'hFFFF, 16'hFFFF, 5'd1, 16'hFFFE, 17);
        issue16(4'h8, 16'hFFFF, 16'hFFFF, 5'd2, 16'h0001, 17);
        issue16(4'h0, 16'hFFFF, 16'h0001, 5'd3, 16'h0000, 1);
        issue16(4'h4, 16'h8000, 16'h0014, 5'd4, 16'hF800, 1);
        issue16(4'hA, 16'hFFFF, 16'h0000, 5'd5, 16'hFFFF, 17);
        issue16(4'hB, 16'h00FF, 16'h0000, 5'd6, 16'h00FF, 17);
        issue16(4'hA, 16'd1000, 16'd33, 5'd7, 16'd30, 17);
        w = 0;
        while ((q16.size() != 0 || busy_h) && w < 200) begin @(posedge clk); #1; w++; end
        if (w >= 200) timeout_fail("drain16");
        done16 = 1'b1;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, handshaked execute unit for the CPU core.
- Handles the existing single-cycle arithmetic/logic/shift opcodes plus new iterative unsigned multiply and divide.
- Sits between decode and writeback. Carries a destination tag so writeback can retire the result out of band.
- Supports a flush so interrupt entry can abandon an in-flight multi-cycle operation.

Parameters:
- XLEN, 32, operand/result width; must be >= 4 and a power of two.
- TAGW, 5, width of the pass-through destination tag (rd index).
- SHW, $clog2(XLEN), derived; shift-amount bits taken from b.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous abort of any operation.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  4  opcode (ALU_OP).
- in_a  in  XLEN  operand a.
- in_b  in  XLEN  operand b.
- in_tag  in  TAGW  destination tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- out_data  out  XLEN  result.
- out_tag  out  TAGW  tag of result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, active-high) puts the FSM in IDLE and clears every register to 0, so all outputs read 0 except in_ready, which reads 1 once rst is low. Reset mid-operation discards the operation; no result is emitted.
- Opcodes:
  - 0 add: a+b.
  - 1 sub: a-b.
  - 2 sll: a << b[SHW-1:0].
  - 3 srl: a >> b[SHW-1:0].
  - 4 sra: arithmetic right shift by b[SHW-1:0].
  - 5 and, 6 or, 7 xor.
  - 8 mul: low XLEN bits of the unsigned product.
  - 9 mulhu: high XLEN bits of the unsigned product.
  - A divu: unsigned quotient.
  - B remu: unsigned remainder.
  - C-F: result 0, single-cycle.
- All arithmetic is modulo 2^XLEN; no flags.
- Handshake:
  - Accept when in_valid && in_ready at a rising edge.
  - in_ready = (state==IDLE) && !flush.
  - Result is transferred when out_valid && out_ready.
  - out_data and out_tag are held stable while out_valid && !out_ready.
- FSM states IDLE, BUSY, DONE:
  - IDLE --accept, op 0-7 or C-F--> DONE. Result registered; out_valid is high in the cycle after acceptance (latency 1).
  - IDLE --accept, op 8-B--> BUSY. Load operands, cnt = XLEN-1, clear the 2*XLEN accumulator.
  - BUSY: one shift-add (mul) or restoring subtract-shift (div) step per cycle. At the step where cnt==0, go to DONE. out_valid first high in cycle accept+XLEN+1.
  - DONE --out_ready--> IDLE. No accept in the same cycle, so minimum issue interval is 2 cycles for single-cycle ops.
- Division by zero: no trap.
  - divu returns all ones.
  - remu returns a.
  - Timing is still XLEN+1, so latency is data-independent.
- Flush has priority over everything else:
  - Any state goes to IDLE at the next edge, and out_valid is 0 from that cycle.
  - A flush coinciding with out_valid && out_ready: the transfer is counted as taken, and the state still goes to IDLE.
  - A flush with in_valid high: no accept, because in_ready is low.
- The tag is captured at accept and presented unchanged on out_tag.
- busy is high in BUSY and DONE.

Decomposition:
- Shared package lib_alu_iter holds:
  - typedef enum logic [3:0] ALU_OP covering ops 0-B.
  - typedef enum ALU_STATE {IDLE, BUSY, DONE}.
  - Function fn_calc_w (parametrised-width version of the single-cycle calculator), reused by the combinational path.
- One sub-module, muldiv_iter: iterative datapath with start, op, a, b in and done, result out. Its accumulator and counter are owned by alu_iter's BUSY state.

Test Plan:
1. XLEN=32, add a=5 b=0xFFFFFFFD (-3), tag=7, out_ready=1 -> out_valid in cycle accept+1, out_data=2, out_tag=7, back to IDLE next cycle.
2. sra a=0x80000000 b=0x24 (shift uses only b[4:0]=4) -> 0xF8000000. Same with srl -> 0x08000000.
3. mul and mulhu a=0x00010000 b=0x00010000 -> mul 0x00000000, mulhu 0x00000001. out_valid first high exactly 33 cycles after accept; in_ready low throughout.
4. divu 100/7 -> 14, remu -> 2. divu a=0x1234 b=0 -> 0xFFFFFFFF, remu -> 0x1234, same 33-cycle latency.
5. Backpressure: out_ready held 0 for 10 cycles after out_valid -> out_data/out_tag stable, in_ready 0, no second accept. out_ready=1 -> one transfer, IDLE.
6. flush asserted at BUSY cycle 5 of a divu -> IDLE next cycle, no out_valid, new add accepted and correct. Repeat with rst pulsed mid-BUSY and with XLEN=16 (mulhu 0xFFFF*0xFFFF -> 0xFFFE, 17-cycle latency).
